// File: rtl/vga_capture_pkg.sv
// Shared VGA timing constants, capture FSM encoding and a small counter helper.
// The timing generator pulls its default 640x480@60 numbers from here too.
package vga_capture_pkg;

    localparam int VGA_H_FRAME      = 800;
    localparam int VGA_H_SYNC_PULSE = 96;
    localparam int VGA_H_BACK_PORCH = 48;
    localparam int VGA_H_VISIBLE    = 640;
    localparam int VGA_V_FRAME      = 525;
    localparam int VGA_V_SYNC_PULSE = 2;
    localparam int VGA_V_BACK_PORCH = 33;
    localparam int VGA_V_VISIBLE    = 480;
    localparam int VGA_LOCK_FRAMES  = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } cap_state_e;

    // 16-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vga_sync_detector.sv
// Sync edge detection plus horizontal/vertical position counters.
// h_pos/v_pos are the positions of the sample being presented this cycle;
// h_cnt/v_cnt hold the positions of the previous sample.
module vga_sync_detector
    import vga_capture_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] h_pos,
    output logic [15:0] v_pos,
    output logic [15:0] h_cnt,
    output logic [15:0] v_cnt
);

    logic h_sync_q;   // h_sync on the previous sample
    logic line_vs_q;  // v_sync seen at the previous line start

    assign line_start  = en && !h_sync && h_sync_q;
    assign frame_start = line_start && !v_sync && line_vs_q;

    // position of the current sample
    always_comb begin
        h_pos = sat_inc16(h_cnt);
        v_pos = v_cnt;
        if (line_start)
            h_pos = '0;
        if (frame_start)
            v_pos = '0;
        else if (line_start)
            v_pos = sat_inc16(v_cnt);
    end

    // sync history and counters advance only on samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_sync_q  <= 1'b1;
            line_vs_q <= 1'b1;
            h_cnt     <= '0;
            v_cnt     <= '0;
        end else if (en) begin
            h_sync_q <= h_sync;
            if (line_start)
                line_vs_q <= v_sync;
            h_cnt <= h_pos;
            v_cnt <= v_pos;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// VGA timing lock and visible-pixel capture. Measures line/frame lengths,
// locks after Lock_Frames clean frames, and streams visible pixels with a
// linear address once a full frame boundary has been seen while locked.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int H_Frame        = VGA_H_FRAME,
    parameter int V_Frame        = VGA_V_FRAME,
    parameter int H_Sync_Pulse   = VGA_H_SYNC_PULSE,
    parameter int H_Back_Porch   = VGA_H_BACK_PORCH,
    parameter int H_Visible_Area = VGA_H_VISIBLE,
    parameter int V_Sync_Pulse   = VGA_V_SYNC_PULSE,
    parameter int V_Back_Porch   = VGA_V_BACK_PORCH,
    parameter int V_Visible_Area = VGA_V_VISIBLE,
    parameter int Lock_Frames    = VGA_LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [3:0]  Red,
    input  logic [3:0]  Green,
    input  logic [3:0]  Blue,
    output logic        locked,
    output logic        timing_err,
    output logic [15:0] line_len,
    output logic [15:0] frame_lines,
    output logic        pixel_valid,
    output logic [15:0] pixel_data,
    output logic [31:0] pixel_ADDR
);

    localparam logic [15:0] H_LEN   = 16'(H_Frame);
    localparam logic [15:0] V_LEN   = 16'(V_Frame);
    localparam logic [15:0] H_FIRST = 16'(H_Sync_Pulse + H_Back_Porch);
    localparam logic [15:0] H_LAST  = 16'(H_Sync_Pulse + H_Back_Porch + H_Visible_Area - 1);
    localparam logic [15:0] V_FIRST = 16'(V_Sync_Pulse + V_Back_Porch);
    localparam logic [15:0] V_LAST  = 16'(V_Sync_Pulse + V_Back_Porch + V_Visible_Area - 1);
    localparam logic [15:0] TIMEOUT = 16'(2 * H_Frame);
    localparam logic [7:0]  LOCK_N  = 8'(Lock_Frames);

    logic        line_start, frame_start;
    logic [15:0] h_pos, v_pos, h_cnt, v_cnt;

    vga_sync_detector u_sync (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .line_start  (line_start),
        .frame_start (frame_start),
        .h_pos       (h_pos),
        .v_pos       (v_pos),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt)
    );

    logic [15:0] meas_len, meas_lines;
    logic        len_bad, lines_bad, timeout, visible;

    assign meas_len   = h_cnt + 16'd1;
    assign meas_lines = v_cnt + 16'd1;
    assign len_bad    = line_start && (meas_len != H_LEN);
    assign lines_bad  = frame_start && (meas_lines != V_LEN);
    // h_pos counts samples since the last line start, so it doubles as the watchdog
    assign timeout    = en && !line_start && (h_pos >= TIMEOUT);
    assign visible    = (h_pos >= H_FIRST) && (h_pos <= H_LAST) &&
                        (v_pos >= V_FIRST) && (v_pos <= V_LAST);

    cap_state_e  state, state_n;
    logic [7:0]  good_cnt, good_cnt_n;
    logic        bad, bad_n;
    logic        lose;

    // FSM state, good-frame count and per-frame bad flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
            bad      <= 1'b0;
        end else begin
            state    <= state_n;
            good_cnt <= good_cnt_n;
            bad      <= bad_n;
        end
    end

    // next state; lose flags a drop out of LOCKED on this sample
    always_comb begin
        state_n    = state;
        good_cnt_n = good_cnt;
        bad_n      = bad;
        lose       = 1'b0;
        if (en) begin
            case (state)
                SEARCH: begin
                    if (frame_start) begin
                        state_n    = ALIGN;
                        good_cnt_n = '0;
                        bad_n      = 1'b0;
                    end
                end
                ALIGN: begin
                    if (timeout) begin
                        state_n = SEARCH;
                    end else if (frame_start) begin
                        bad_n = 1'b0;
                        // the line closing this frame counts toward its verdict
                        if (!bad && !len_bad && !lines_bad) begin
                            good_cnt_n = good_cnt + 8'd1;
                            if (good_cnt_n == LOCK_N)
                                state_n = LOCKED;
                        end else begin
                            good_cnt_n = '0;
                        end
                    end else if (len_bad) begin
                        bad_n = 1'b1;
                    end
                end
                LOCKED: begin
                    if (timeout || len_bad || lines_bad) begin
                        lose    = 1'b1;
                        state_n = SEARCH;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    assign locked = (state == LOCKED);

    logic        armed;    // a frame start has been seen while already locked
    logic        capture;
    logic [31:0] addr_next, addr_cur;

    assign capture  = en && locked && armed && !lose && visible;
    assign addr_cur = frame_start ? 32'd0 : addr_next;

    // measurements, error pulse and pixel output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_len    <= '0;
            frame_lines <= '0;
            timing_err  <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
            pixel_ADDR  <= '0;
            addr_next   <= '0;
            armed       <= 1'b0;
        end else begin
            timing_err  <= lose;
            pixel_valid <= capture;
            if (en) begin
                if (line_start)
                    line_len <= meas_len;
                if (frame_start)
                    frame_lines <= meas_lines;
                if (state_n != LOCKED)
                    armed <= 1'b0;
                else if (frame_start && locked)
                    armed <= 1'b1;
                if (capture) begin
                    pixel_data <= {4'h0, Red, Green, Blue};
                    pixel_ADDR <= addr_cur;
                    addr_next  <= addr_cur + 32'd1;
                end else if (frame_start) begin
                    pixel_ADDR <= '0;
                    addr_next  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture using a scaled-down 32x16 timing so whole frames
// fit in a short run. A line/frame-level model predicts lock, error pulses
// and the exact pixel stream; a scenario table checks milestones.
module tb_vga_capture;

    localparam int HF = 32, HS = 4, HB = 4, HV = 20;
    localparam int VF = 16, VS = 2, VB = 3, VV = 8;
    localparam int LF = 2;
    localparam int HV0 = HS + HB, HV1 = HS + HB + HV - 1;
    localparam int VV0 = VS + VB, VV1 = VS + VB + VV - 1;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, h_sync = 1'b1, v_sync = 1'b1;
    logic [3:0]  red = '0, green = '0, blue = '0;
    logic        locked, timing_err, pixel_valid;
    logic [15:0] line_len, frame_lines, pixel_data;
    logic [31:0] pixel_ADDR;

    vga_capture #(
        .H_Frame(HF), .V_Frame(VF), .H_Sync_Pulse(HS), .H_Back_Porch(HB),
        .H_Visible_Area(HV), .V_Sync_Pulse(VS), .V_Back_Porch(VB),
        .V_Visible_Area(VV), .Lock_Frames(LF)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .h_sync(h_sync), .v_sync(v_sync),
        .Red(red), .Green(green), .Blue(blue),
        .locked(locked), .timing_err(timing_err), .line_len(line_len),
        .frame_lines(frame_lines), .pixel_valid(pixel_valid),
        .pixel_data(pixel_data), .pixel_ADDR(pixel_ADDR)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0, mis_cnt = 0;
    int dut_err = 0, pix_total = 0, pix_base = 0;
    int gap_lo = 1, gap_hi = 1;

    // model: 0 searching, 1 aligning, 2 locked
    int m_st, m_good, m_addr, m_since, m_nlines;
    bit m_bad, m_cap, m_phs, m_plvs;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_st = 0; m_good = 0; m_addr = 0; m_bad = 0; m_cap = 0;
        m_since = 1; m_nlines = 1; m_phs = 1; m_plvs = 1;
    endfunction

    // one pixel-time: update model, drive one en pulse, check the result
    task automatic samp(input bit hs, input bit vs, input int h, input int v);
        logic [3:0] r, g, b;
        bit ls, fs, exp_te, exp_pv;
        int exp_addr;
        r = 4'($urandom); g = 4'($urandom); b = 4'($urandom);
        exp_te = 0; exp_pv = 0; exp_addr = 0;
        ls = !hs && m_phs;
        fs = ls && !vs && m_plvs;
        if (ls) begin
            case (m_st)
                0: if (fs) begin m_st = 1; m_good = 0; m_bad = 0; end
                1: begin
                    if (m_since != HF) m_bad = 1;
                    if (fs) begin
                        if (!m_bad && m_nlines == VF) m_good++; else m_good = 0;
                        m_bad = 0;
                        if (m_good == LF) m_st = 2;
                    end
                end
                default: begin
                    if (m_since != HF || (fs && m_nlines != VF)) begin
                        m_st = 0; m_cap = 0; exp_te = 1;
                    end else if (fs) begin
                        m_cap = 1; m_addr = 0;
                    end
                end
            endcase
            m_since = 0;
            if (fs) m_nlines = 1; else m_nlines++;
            m_plvs = vs;
        end else if (m_since >= 2 * HF && m_st != 0) begin
            if (m_st == 2) exp_te = 1;
            m_st = 0; m_cap = 0;
        end
        m_since++;
        m_phs = hs;
        if (m_st == 2 && m_cap && h >= HV0 && h <= HV1 && v >= VV0 && v <= VV1) begin
            exp_pv = 1; exp_addr = m_addr; m_addr++;
        end

        @(negedge clk);
        chk("idle_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("idle_timing_err", 32'(timing_err), 32'd0);
        en = 1'b1; h_sync = hs; v_sync = vs; red = r; green = g; blue = b;
        @(negedge clk);
        en = 1'b0;
        chk("locked", 32'(locked), 32'(m_st == 2));
        chk("timing_err", 32'(timing_err), 32'(exp_te));
        chk("pixel_valid", 32'(pixel_valid), 32'(exp_pv));
        if (exp_pv && pixel_valid) begin
            chk("pixel_ADDR", pixel_ADDR, 32'(exp_addr));
            chk("pixel_data", {16'd0, pixel_data}, {16'd0, 4'h0, r, g, b});
        end
        if (timing_err) dut_err++;
        if (pixel_valid) pix_total++;
        repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
    endtask

    task automatic send_line(input int len, input int v, input bit vs);
        for (int h = 0; h < len; h++) samp(h >= HS, vs, h, v);
    endtask

    task automatic send_frame(input int nlines, input int short_at);
        for (int v = 0; v < nlines; v++) send_line((v == short_at) ? HF - 1 : HF, v, v >= VS);
    endtask

    // no h_sync edges at all; h keeps counting so nothing looks visible
    task automatic dead_time(input int n);
        for (int i = 0; i < n; i++) samp(1'b1, 1'b1, HF + i, VF);
    endtask

    task automatic checkpoint(input string nm, input bit e_lk, input int e_err,
                              input int e_pix, input int e_ll, input int e_fl);
        chk({nm, "_locked"}, 32'(locked), 32'(e_lk));
        chk({nm, "_err_pulses"}, 32'(dut_err), 32'(e_err));
        chk({nm, "_pixels"}, 32'(pix_total - pix_base), 32'(e_pix));
        chk({nm, "_line_len"}, {16'd0, line_len}, 32'(e_ll));
        chk({nm, "_frame_lines"}, {16'd0, frame_lines}, 32'(e_fl));
        pix_base = pix_total;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_locked"}, 32'(locked), 32'd0);
        chk({nm, "_timing_err"}, 32'(timing_err), 32'd0);
        chk({nm, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        chk({nm, "_pixel_data"}, {16'd0, pixel_data}, 32'd0);
        chk({nm, "_pixel_ADDR"}, pixel_ADDR, 32'd0);
        chk({nm, "_line_len"}, {16'd0, line_len}, 32'd0);
        chk({nm, "_frame_lines"}, {16'd0, frame_lines}, 32'd0);
    endtask

    typedef struct {
        int nfr;       // frames to send
        int nlines;    // lines per frame
        int short_at;  // line sent one sample short, -1 for none
        bit dead;      // follow with 2.5 lines of no h_sync
        bit e_lk;      // expected locked afterwards
        int e_err;     // cumulative timing_err pulses
        int e_pix;     // pixels captured during this row
        int e_ll;
        int e_fl;
    } row_t;

    row_t tbl [11];

    initial begin
        #(2000000);
        $display("FAIL watchdog: time limit reached, got %0d vectors, expected completion", vec_cnt);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{2, VF, -1, 1'b0, 1'b0, 0, 0,   HF, VF}; // two clean frames: not yet locked
        tbl[1]  = '{1, VF, -1, 1'b0, 1'b1, 0, 0,   HF, VF}; // locks at the third frame start
        tbl[2]  = '{1, VF, -1, 1'b0, 1'b1, 0, 160, HF, VF}; // full capture
        tbl[3]  = '{1, VF,  7, 1'b0, 1'b0, 1, 60,  HF, VF}; // short line 7 drops lock
        tbl[4]  = '{2, VF, -1, 1'b0, 1'b0, 1, 0,   HF, VF};
        tbl[5]  = '{1, VF, -1, 1'b0, 1'b1, 1, 0,   HF, VF}; // relocked, no capture yet
        tbl[6]  = '{1, VF, -1, 1'b0, 1'b1, 1, 160, HF, VF};
        tbl[7]  = '{1, VF, -1, 1'b1, 1'b0, 2, 160, HF, VF}; // h_sync watchdog
        tbl[8]  = '{2, VF, -1, 1'b0, 1'b0, 2, 0,   HF, VF};
        tbl[9]  = '{1, VF, -1, 1'b0, 1'b1, 2, 0,   HF, VF};
        tbl[10] = '{1, VF, -1, 1'b0, 1'b1, 2, 160, HF, VF};

        m_reset();
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            for (int f = 0; f < tbl[i].nfr; f++) send_frame(tbl[i].nlines, tbl[i].short_at);
            if (tbl[i].dead) dead_time(5 * HF / 2);
            checkpoint($sformatf("row%0d", i), tbl[i].e_lk, tbl[i].e_err,
                       tbl[i].e_pix, tbl[i].e_ll, tbl[i].e_fl);
        end

        // reset in the middle of a captured frame
        gap_lo = 0; gap_hi = 2;
        for (int v = 0; v < 8; v++) send_line(HF, v, v >= VS);
        for (int h = 0; h < 12; h++) samp(h >= HS, 1'b1, h, 8);
        checkpoint("pre_rst", 1'b1, 2, 64, HF, VF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(VF, -1);
        send_frame(VF, -1);
        checkpoint("rst_2fr", 1'b0, 2, 0, HF, VF);
        send_frame(VF, -1);
        checkpoint("rst_3fr", 1'b1, 2, 0, HF, VF);

        // one line short per frame: never locks, never flags an error
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int f = 0; f < 4; f++) send_frame(VF - 1, -1);
        checkpoint("short_frames", 1'b0, 2, 0, HF, VF - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_Frame, default 800, pixel samples per line.
REQ-002 SHALL have parameter V_Frame, default 525, lines per frame.
REQ-003 SHALL have parameters H_Sync_Pulse 96, H_Back_Porch 48, H_Visible_Area 640, V_Sync_Pulse 2, V_Back_Porch 33, V_Visible_Area 480, with the usual VGA meanings.
REQ-004 SHALL have parameter Lock_Frames, default 2, consecutive good frames required for lock.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, named as follows.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port en, input, 1, pixel strobe; one clk-wide pulse per pixel time.
REQ-009 SHALL have port h_sync, input, 1, active-low horizontal sync.
REQ-010 SHALL have port v_sync, input, 1, active-low vertical sync.
REQ-011 SHALL have ports Red, Green and Blue, inputs, 4 each, colour samples.
REQ-012 SHALL have port locked, output, 1, timing lock indicator.
REQ-013 SHALL have port timing_err, output, 1, one-cycle pulse on loss of lock.
REQ-014 SHALL have port line_len, output, 16, last measured samples per line.
REQ-015 SHALL have port frame_lines, output, 16, last measured lines per frame.
REQ-016 SHALL have port pixel_valid, output, 1, one-cycle pulse per captured visible pixel.
REQ-017 SHALL have port pixel_data, output, 16, {4'h0, Red, Green, Blue}.
REQ-018 SHALL have port pixel_ADDR, output, 32, linear visible-pixel index.

Function
REQ-019 SHALL act only on clk cycles where en=1 ("samples"); all other cycles hold state.
REQ-020 SHALL detect a line start when h_sync=0 on a sample and was 1 on the previous sample.
REQ-021 SHALL detect a frame start at the first line start on which v_sync=0 and whose previous line had v_sync=1.
REQ-022 SHALL set h_cnt=0 on a line-start sample; otherwise h_cnt SHALL increment, saturating at 16'hFFFF.
REQ-023 SHALL set v_cnt=0 on a frame start; otherwise v_cnt SHALL increment on each line start, saturating.
REQ-024 SHALL, on each line start, load line_len with (h_cnt of the previous sample)+1.
REQ-025 SHALL, on each frame start, load frame_lines with (v_cnt of the previous line)+1.
REQ-026 SHALL implement an FSM with states SEARCH, ALIGN and LOCKED; reset state SEARCH.
REQ-027 SHALL transition SEARCH->ALIGN on a frame start, clearing the good-frame count and the bad flag.
REQ-028 SHALL, in ALIGN, set the bad flag on any line start where line_len != H_Frame.
REQ-029 SHALL, in ALIGN at each frame start, increment the good-frame count if the bad flag is clear and frame_lines = V_Frame; otherwise clear the count. The bad flag SHALL clear at each frame start.
REQ-030 SHALL transition ALIGN->LOCKED when the good-frame count reaches Lock_Frames.
REQ-031 SHALL transition LOCKED->SEARCH and pulse timing_err for one clk if any of the following occurs: line_len != H_Frame at a line start; frame_lines != V_Frame at a frame start; or 2*H_Frame samples pass with no line start.
REQ-032 SHALL apply the same 2*H_Frame no-line-start timeout in ALIGN, returning to SEARCH without pulsing timing_err.
REQ-033 SHALL drive locked=1 exactly while the state is LOCKED.
REQ-034 SHALL classify a sample as visible when h_cnt is in [144,783] and v_cnt is in [35,514], with bounds derived from the parameters.
REQ-035 SHALL, for a visible sample while LOCKED, assert pixel_valid on the next clk with pixel_data holding the sampled colours (latency 1 clk).
REQ-036 SHALL drive pixel_ADDR as a running count: 0 at the first visible pixel of a frame, +1 per valid pixel, reset on frame start; the last pixel of a frame SHALL be 307199.
REQ-037 SHALL give loss-of-lock priority over capture when both occur on the same sample: no pixel_valid on that sample.
REQ-038 SHALL NOT resume capture after relock until the next frame start, so pixel_ADDR always begins at 0.

Reset
REQ-039 SHALL, on rst, drive locked=0, timing_err=0, pixel_valid=0, pixel_data=0, pixel_ADDR=0, line_len=0, frame_lines=0, state SEARCH, all counters 0, and previous-sync registers 1.
REQ-040 SHALL abandon any partial frame on rst asserted mid-frame, with no pixel_valid afterwards until relock.

Structure
REQ-041 SHALL place the VGA timing constants and FSM state encodings in a shared package also used by the timing generator.
REQ-042 SHALL implement sync edge detection and h_cnt/v_cnt counting in one sub-module, vga_sync_detector.

Verification
REQ-043 SHALL verify: drive generator-style 800x525 timing with en every 3rd clk -> locked=1 after the 2nd complete frame; line_len=800; frame_lines=525.
REQ-044 SHALL verify: while locked, one full frame -> exactly 307200 pixel_valid pulses; pixel_ADDR 0..307199; first pulse at h=144, v=35.
REQ-045 SHALL verify: while locked, one line of 799 samples -> timing_err pulse, locked=0, pixel_valid stops; relock after 2 good frames.
REQ-046 SHALL verify: while locked, hold h_sync=1 for 1600 samples -> timing_err, state SEARCH.
REQ-047 SHALL verify: assert rst mid-frame with locked=1 -> all outputs 0 in the same cycle; relock only after 2 full good frames.
REQ-048 SHALL verify: send 524-line frames -> never locks; timing_err remains 0.
